// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one two-entry skid buffer per channel, so VALID, READY
// and payload are all driven from flops on both sides of the slice.

module axi_reg_slice_skid #(
  parameter int W            = 8,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         in_ready_reg, in_ready_next;
  logic         out_valid_reg, out_valid_next;
  logic         skid_valid_reg, skid_valid_next;
  logic [W-1:0] out_data_reg, out_data_next;
  logic [W-1:0] skid_data_reg, skid_data_next;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;

  always_comb begin
    out_valid_next  = out_valid_reg;
    skid_valid_next = skid_valid_reg;
    out_data_next   = out_data_reg;
    skid_data_next  = skid_data_reg;
    if (skid_valid_reg) begin
      // FULL: input is blocked, only the output side can move
      if (out_fire) begin
        out_data_next   = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_reg || out_fire) begin
        out_valid_next = 1'b1;
        out_data_next  = in_data;
      end else begin
        skid_valid_next = 1'b1;
        skid_data_next  = in_data;
      end
    end else if (out_fire) begin
      out_valid_next = 1'b0;
    end
    if (OPT_LOWPOWER) begin
      if (!out_valid_next)  out_data_next  = '0;
      if (!skid_valid_next) skid_data_next = '0;
    end
    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      in_ready_reg   <= in_ready_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  // Payload flops only take a reset when low-power mode wants them zeroed.
  generate
    if (OPT_LOWPOWER) begin : g_lowpower
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_data_reg  <= '0;
          skid_data_reg <= '0;
        end else begin
          out_data_reg  <= out_data_next;
          skid_data_reg <= skid_data_next;
        end
      end
    end else begin : g_plain
      always_ff @(posedge clk) begin
        out_data_reg  <= out_data_next;
        skid_data_reg <= skid_data_next;
      end
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

module axi_reg_slice #(
  parameter int C_AXI_ID_WIDTH   = 2,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int OPT_LOWPOWER     = 0
) (
  input  logic                                             S_AXI_ACLK,
  input  logic                                             S_AXI_ARESETN,
  input  logic                                             S_AXI_AWVALID,
  output logic                                             S_AXI_AWREADY,
  input  logic [C_AXI_ID_WIDTH+C_AXI_ADDR_WIDTH+24:0]      S_AXI_AWPAYLOAD,
  output logic                                             M_AXI_AWVALID,
  input  logic                                             M_AXI_AWREADY,
  output logic [C_AXI_ID_WIDTH+C_AXI_ADDR_WIDTH+24:0]      M_AXI_AWPAYLOAD,
  input  logic                                             S_AXI_WVALID,
  output logic                                             S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH+C_AXI_DATA_WIDTH/8:0]     S_AXI_WPAYLOAD,
  output logic                                             M_AXI_WVALID,
  input  logic                                             M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH+C_AXI_DATA_WIDTH/8:0]     M_AXI_WPAYLOAD,
  input  logic                                             M_AXI_BVALID,
  output logic                                             M_AXI_BREADY,
  input  logic [C_AXI_ID_WIDTH+1:0]                        M_AXI_BPAYLOAD,
  output logic                                             S_AXI_BVALID,
  input  logic                                             S_AXI_BREADY,
  output logic [C_AXI_ID_WIDTH+1:0]                        S_AXI_BPAYLOAD,
  input  logic                                             S_AXI_ARVALID,
  output logic                                             S_AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH+C_AXI_ADDR_WIDTH+24:0]      S_AXI_ARPAYLOAD,
  output logic                                             M_AXI_ARVALID,
  input  logic                                             M_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH+C_AXI_ADDR_WIDTH+24:0]      M_AXI_ARPAYLOAD,
  input  logic                                             M_AXI_RVALID,
  output logic                                             M_AXI_RREADY,
  input  logic [C_AXI_ID_WIDTH+C_AXI_DATA_WIDTH+2:0]       M_AXI_RPAYLOAD,
  output logic                                             S_AXI_RVALID,
  input  logic                                             S_AXI_RREADY,
  output logic [C_AXI_ID_WIDTH+C_AXI_DATA_WIDTH+2:0]       S_AXI_RPAYLOAD
);

  localparam int  AXW = C_AXI_ID_WIDTH + C_AXI_ADDR_WIDTH + 25;
  localparam int  WW  = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH/8 + 1;
  localparam int  BW  = C_AXI_ID_WIDTH + 2;
  localparam int  RW  = C_AXI_ID_WIDTH + C_AXI_DATA_WIDTH + 3;
  localparam bit  LP  = (OPT_LOWPOWER != 0);

  // Forward channels: S side in, M side out
  axi_reg_slice_skid #(.W(AXW), .OPT_LOWPOWER(LP)) u_aw (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .in_valid(S_AXI_AWVALID), .in_ready(S_AXI_AWREADY), .in_data(S_AXI_AWPAYLOAD),
    .out_valid(M_AXI_AWVALID), .out_ready(M_AXI_AWREADY), .out_data(M_AXI_AWPAYLOAD)
  );

  axi_reg_slice_skid #(.W(WW), .OPT_LOWPOWER(LP)) u_w (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .in_valid(S_AXI_WVALID), .in_ready(S_AXI_WREADY), .in_data(S_AXI_WPAYLOAD),
    .out_valid(M_AXI_WVALID), .out_ready(M_AXI_WREADY), .out_data(M_AXI_WPAYLOAD)
  );

  axi_reg_slice_skid #(.W(AXW), .OPT_LOWPOWER(LP)) u_ar (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .in_valid(S_AXI_ARVALID), .in_ready(S_AXI_ARREADY), .in_data(S_AXI_ARPAYLOAD),
    .out_valid(M_AXI_ARVALID), .out_ready(M_AXI_ARREADY), .out_data(M_AXI_ARPAYLOAD)
  );

  // Reverse channels: M side in, S side out
  axi_reg_slice_skid #(.W(BW), .OPT_LOWPOWER(LP)) u_b (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .in_valid(M_AXI_BVALID), .in_ready(M_AXI_BREADY), .in_data(M_AXI_BPAYLOAD),
    .out_valid(S_AXI_BVALID), .out_ready(S_AXI_BREADY), .out_data(S_AXI_BPAYLOAD)
  );

  axi_reg_slice_skid #(.W(RW), .OPT_LOWPOWER(LP)) u_r (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .in_valid(M_AXI_RVALID), .in_ready(M_AXI_RREADY), .in_data(M_AXI_RPAYLOAD),
    .out_valid(S_AXI_RVALID), .out_ready(S_AXI_RREADY), .out_data(S_AXI_RPAYLOAD)
  );

endmodule
